// File: rtl/qspi_sram_responder_pkg.sv
// rtl/qspi_sram_responder_pkg.sv - shared constants and state encoding for the SQI SRAM responder
//
// Contents:
//   CMD_*          command opcodes understood by the responder
//   ADDR_NIBBLES   address length in quad nibbles (24 bits)
//   DUMMY_NIBBLES  dummy nibbles between READ address and data
//   state_t        protocol FSM states
package qspi_sram_responder_pkg;

  localparam logic [7:0] CMD_EQIO   = 8'h38;
  localparam logic [7:0] CMD_RSTQIO = 8'hFF;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;

  localparam int ADDR_NIBBLES  = 6;
  localparam int DUMMY_NIBBLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    WDATA,
    RDATA,
    DONE
  } state_t;

endpackage

// File: rtl/qspi_sram_responder_mem.sv
// rtl/qspi_sram_responder_mem.sv - single-port byte array with synchronous read
//
// Ports:
//   clk    system clock
//   we     write enable; when high the cycle is a write, otherwise a read
//   addr   byte address
//   wdata  byte to store
//   rdata  registered read data (mem[addr] of the previous non-write cycle)
module qspi_sram_responder_mem #(
  parameter int DEPTH_BYTES = 65536,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/qspi_sram_responder.sv
// rtl/qspi_sram_responder.sv - SQI serial SRAM responder: protocol FSM around a byte array
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   sram_cs_n       chip select, active low
//   sram_sck        serial clock (mode 0), sampled as data and edge-detected
//   sram_sio_i      sio3..sio0 from the initiator
//   sram_sio_o      sio3..sio0 driven during reads
//   sram_sio_oe     responder drives sio
//   quad_mode       SQI mode active
//   protocol_error  one-clk pulse on an unsupported command
module qspi_sram_responder
  import qspi_sram_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 65536,
  parameter bit START_QUAD  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sram_cs_n,
  input  logic       sram_sck,
  input  logic [3:0] sram_sio_i,
  output logic [3:0] sram_sio_o,
  output logic       sram_sio_oe,
  output logic       quad_mode,
  output logic       protocol_error
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_t      state, state_next;
  logic        sck_q, rise, fall;
  logic [3:0]  cnt;
  logic [6:0]  sr;
  logic [7:0]  shift_in, cmd, rd_byte;
  logic [23:0] addr;
  logic        nib_lo, oe_q;
  logic        cmd_last, shifting;
  logic        mem_we, err_set, quad_set, quad_clr;

  assign rise     = sram_sck & ~sck_q;
  assign fall     = ~sram_sck & sck_q;
  // Byte assembled including the sample taken on this rise.
  assign shift_in = quad_mode ? {sr[3:0], sram_sio_i} : {sr, sram_sio_i[0]};
  assign cmd_last = quad_mode ? (cnt == 4'd1) : (cnt == 4'd7);
  assign shifting = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == WDATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    err_set    = 1'b0;
    quad_set   = 1'b0;
    quad_clr   = 1'b0;
    case (state)
      IDLE: state_next = CMD;
      CMD: begin
        if (rise && cmd_last) begin
          if (!quad_mode) begin
            if (shift_in == CMD_EQIO) begin
              quad_set = 1'b1;
            end else begin
              err_set = 1'b1;
            end
            state_next = DONE;
          end else if (shift_in == CMD_RSTQIO) begin
            quad_clr   = 1'b1;
            state_next = DONE;
          end else if (shift_in == CMD_WRITE || shift_in == CMD_READ) begin
            state_next = ADDR;
          end else begin
            err_set    = 1'b1;
            state_next = DONE;
          end
        end
      end
      ADDR: begin
        if (rise && cnt == 4'(ADDR_NIBBLES - 1)) begin
          state_next = (cmd == CMD_WRITE) ? WDATA : DUMMY;
        end
      end
      DUMMY: begin
        if (rise && cnt == 4'(DUMMY_NIBBLES - 1)) begin
          state_next = RDATA;
        end
      end
      // A byte is committed on the rise carrying its low nibble, so a
      // deselect or reset can only ever drop a whole byte.
      WDATA:       mem_we = rise & cnt[0];
      RDATA, DONE: state_next = state;
      default:     state_next = IDLE;
    endcase
    // Deselect and reset override any edge seen in the same cycle.
    if (sram_cs_n || reset) begin
      state_next = IDLE;
      mem_we     = 1'b0;
      err_set    = 1'b0;
      quad_set   = 1'b0;
      quad_clr   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    sck_q <= sram_sck;
    if (reset) begin
      quad_mode      <= START_QUAD;
      protocol_error <= 1'b0;
      sram_sio_o     <= 4'd0;
      oe_q           <= 1'b0;
      cnt            <= 4'd0;
      nib_lo         <= 1'b0;
      sr             <= 7'd0;
      cmd            <= 8'd0;
      addr           <= 24'd0;
    end else begin
      protocol_error <= err_set;
      if (quad_set) begin
        quad_mode <= 1'b1;
      end else if (quad_clr) begin
        quad_mode <= 1'b0;
      end

      if (sram_cs_n || state_next != state) begin
        cnt    <= 4'd0;
        nib_lo <= 1'b0;
      end else if (rise && shifting) begin
        cnt <= cnt + 4'd1;
      end

      if (!sram_cs_n && rise && shifting) begin
        sr <= shift_in[6:0];
      end
      if (state == CMD && state_next == ADDR) begin
        cmd <= shift_in;
      end
      if (!sram_cs_n && rise && state == ADDR) begin
        addr <= {addr[19:0], sram_sio_i};
      end
      if (mem_we) begin
        addr <= addr + 24'd1;
      end

      // The memory reads addr every non-write cycle, so rd_byte follows
      // addr one clk later; sck needs at least two clks between falls,
      // which keeps the next byte ready by the time its high nibble goes out.
      if (state_next != RDATA) begin
        oe_q <= 1'b0;
      end else if (state == RDATA && fall) begin
        oe_q       <= 1'b1;
        sram_sio_o <= nib_lo ? rd_byte[3:0] : rd_byte[7:4];
        nib_lo     <= ~nib_lo;
        if (nib_lo) begin
          addr <= addr + 24'd1;
        end
      end
    end
  end

  assign sram_sio_oe = oe_q & ~sram_cs_n & ~reset & (state == RDATA);

  // Only the low AW address bits reach the array, so the address wraps.
  qspi_sram_responder_mem #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .AW         (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr[AW-1:0]),
    .wdata(shift_in),
    .rdata(rd_byte)
  );

endmodule
